// File: rtl/alu_share_sched_if.sv
// Request/grant/done bundle between two requesters and the shared ALU scheduler.
// Latency: n/a (wires only); the scheduler registers every output it drives here.
// Backpressure: requesters hold req until their done pulse; no other flow control.
//
// Signals: req[1:0], op0/op1[1:0], a0/b0/a1/b1[2:0] from requesters;
//          gnt[1:0], done[1:0], res[2:0], ovf, busy, ops_done[7:0] from the scheduler.
interface alu_share_sched_if #(
    parameter int NBITS_OP  = 3,
    parameter int NBITS_CNT = 8
);
    logic [1:0]           req;
    logic [1:0]           op0;
    logic [1:0]           op1;
    logic [NBITS_OP-1:0]  a0;
    logic [NBITS_OP-1:0]  b0;
    logic [NBITS_OP-1:0]  a1;
    logic [NBITS_OP-1:0]  b1;
    logic [1:0]           gnt;
    logic [1:0]           done;
    logic [NBITS_OP-1:0]  res;
    logic                 ovf;
    logic                 busy;
    logic [NBITS_CNT-1:0] ops_done;

    modport master (
        output req, op0, op1, a0, b0, a1, b1,
        input  gnt, done, res, ovf, busy, ops_done
    );

    modport slave (
        input  req, op0, op1, a0, b0, a1, b1,
        output gnt, done, res, ovf, busy, ops_done
    );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one signed AND/OR/ADD/SUB ALU between two requesters.
// Latency: 2 cycles from the req sampling edge to done; one operation every 3 cycles.
// Backpressure: req is sampled only in IDLE; a requester waits (holding req) until gnt.
//
// Ports: clk_2, rst_n (async, active-low); bus (alu_share_sched_if.slave):
//   req/op/a/b in, gnt/done pulses, res/ovf result, busy, ops_done counter out.
// Build option: define ALU_SAT_EN to saturate overflowed ADD/SUB results instead
//   of forcing them to zero (ovf is reported either way).
module alu_share_sched #(
    parameter int NREQ      = 2,
    parameter int NBITS_OP  = 3,
    parameter int NBITS_CNT = 8
) (
    input  logic             clk_2,
    input  logic             rst_n,
    alu_share_sched_if.slave bus
);
    localparam int W = NBITS_OP + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  win_q, win_d;
    logic [1:0]            op_q, op_d;
    logic [NBITS_OP-1:0]   a_q, a_d;
    logic [NBITS_OP-1:0]   b_q, b_d;
    logic [NBITS_OP-1:0]   res_q, res_d;
    logic                  ovf_q, ovf_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [NREQ-1:0]       done_q, done_d;
    logic [NBITS_CNT-1:0]  cnt_q, cnt_d;

    logic                  winner;
    logic [W-1:0]          ax, bx, y;
    logic                  y_ovf;
    logic [NBITS_OP-1:0]   y_res;

    // Both requesting: the one that did not win last time goes next.
    always_comb begin
        winner = 1'b0;
        if (bus.req == 2'b11) begin
            winner = ~last_q;
        end else if (bus.req[1]) begin
            winner = 1'b1;
        end
    end

    // ALU on the latched operands, one bit wider so ADD/SUB cannot wrap.
    always_comb begin
        ax = {a_q[NBITS_OP-1], a_q};
        bx = {b_q[NBITS_OP-1], b_q};
        case (op_q)
            2'b00:   y = ax + bx;
            2'b01:   y = ax - bx;
            2'b10:   y = ax & bx;
            default: y = ax | bx;
        endcase
        // Top two bits disagree => value outside the NBITS_OP signed range.
        y_ovf = ~op_q[1] & (y[W-1] ^ y[W-2]);
        y_res = y[NBITS_OP-1:0];
        if (y_ovf) begin
`ifdef ALU_SAT_EN
            y_res = y[W-1] ? {1'b1, {(NBITS_OP-1){1'b0}}}
                           : {1'b0, {(NBITS_OP-1){1'b1}}};
`else
            y_res = '0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d        = EXEC;
                    win_d          = winner;
                    last_d         = winner;
                    op_d           = winner ? bus.op1 : bus.op0;
                    a_d            = winner ? bus.a1  : bus.a0;
                    b_d            = winner ? bus.b1  : bus.b0;
                    gnt_d[winner]  = 1'b1;
                end
            end
            EXEC: begin
                // done/ops_done are registered here so they appear during RESP,
                // alongside the freshly registered result.
                state_d        = RESP;
                res_d          = y_res;
                ovf_d          = y_ovf;
                done_d[win_q]  = 1'b1;
                cnt_d          = cnt_q + 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.res      = res_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.ops_done = cnt_q;
endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: stimulus pushes expected done responses,
// a negedge monitor pops and compares whenever done is non-zero.
module tb_alu_share_sched;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk_2 = 1'b0;
    logic rst_n;
    always #5 clk_2 = ~clk_2;

    alu_share_sched_if bus ();

    alu_share_sched dut (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] done;
        logic [2:0] res;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_done_cyc = -1;
    bit         gap_chk = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk_2) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk_2) begin
        if (rst_n && bus.done != 2'b00) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=%b with empty scoreboard", bus.done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_who", int'(bus.done), int'(e.done));
                chk("res", int'(bus.res), int'(e.res));
                chk("ovf", int'(bus.ovf), int'(e.ovf));
                chk("ops_done", int'(bus.ops_done), int'(e.cnt));
                chk("gnt_with_done", int'(bus.gnt), 0);
            end
            if (gap_chk) begin
                if (last_done_cyc >= 0) chk("done_gap", cyc - last_done_cyc, 3);
                last_done_cyc = cyc;
            end
        end
    end

    task automatic push_exp(input logic who, input logic [2:0] r, input logic o);
        exp_t e;
        exp_cnt  = exp_cnt + 8'd1;
        e.done   = who ? 2'b10 : 2'b01;
        e.res    = r;
        e.ovf    = o;
        e.cnt    = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_2);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        exp_cnt = 8'd0;
        @(negedge clk_2);
        rst_n = 1'b1;
    endtask

    // Single request: checks gnt at T+1, done at T+2, and that operand changes
    // after the grant do not disturb the result.
    task automatic do_op(input logic who, input logic [1:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] er, input logic eo);
        @(negedge clk_2);
        if (who) begin
            bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req = 2'b10;
        end else begin
            bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req = 2'b01;
        end
        push_exp(who, er, eo);
        @(posedge clk_2); #1;
        chk("gnt", int'(bus.gnt), who ? 2 : 1);
        chk("busy_exec", int'(bus.busy), 1);
        @(negedge clk_2);
        if (who) begin
            bus.op1 = ~op; bus.a1 = ~a; bus.b1 = ~b;
        end else begin
            bus.op0 = ~op; bus.a0 = ~a; bus.b0 = ~b;
        end
        @(posedge clk_2); #1;
        chk("done_timing", int'(bus.done), who ? 2 : 1);
        @(negedge clk_2);
        bus.req = 2'b00;
        @(posedge clk_2);
    endtask

    // Both requesters held for n operations, starting from last==1.
    task automatic contention(input int n);
        @(negedge clk_2);
        bus.op0 = 2'b10; bus.a0 = 3'b101; bus.b0 = 3'b011;
        bus.op1 = 2'b11; bus.a1 = 3'b100; bus.b1 = 3'b001;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) push_exp(1'b0, 3'b001, 1'b0);
            else            push_exp(1'b1, 3'b101, 1'b0);
        end
        last_done_cyc = -1;
        gap_chk       = 1'b1;
        bus.req       = 2'b11;
        @(posedge clk_2);
        repeat (3 * n - 1) @(posedge clk_2);
        @(negedge clk_2);
        bus.req = 2'b00;
        gap_chk = 1'b0;
        @(posedge clk_2);
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 2'b00;
        bus.op0 = 2'b00; bus.a0 = 3'b000; bus.b0 = 3'b000;
        bus.op1 = 2'b00; bus.a1 = 3'b000; bus.b1 = 3'b000;
        repeat (2) @(posedge clk_2);
        #1;
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_res", int'(bus.res), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ops_done", int'(bus.ops_done), 0);
        @(negedge clk_2);
        rst_n = 1'b1;

        // who, op, a, b, expected res, expected ovf
        do_op(1'b0, 2'b00, 3'b001, 3'b010, 3'b011, 1'b0);               // 1+2=3
        do_op(1'b0, 2'b00, 3'b011, 3'b001, SAT ? 3'b011 : 3'b000, 1'b1); // 3+1=4
        do_op(1'b1, 2'b01, 3'b100, 3'b001, SAT ? 3'b100 : 3'b000, 1'b1); // -4-1=-5
        do_op(1'b0, 2'b01, 3'b010, 3'b011, 3'b111, 1'b0);               // 2-3=-1
        do_op(1'b1, 2'b11, 3'b110, 3'b001, 3'b111, 1'b0);               // 110|001
        do_op(1'b1, 2'b00, 3'b100, 3'b111, SAT ? 3'b100 : 3'b000, 1'b1); // -4+-1=-5
        do_op(1'b0, 2'b01, 3'b011, 3'b111, SAT ? 3'b011 : 3'b000, 1'b1); // 3-(-1)=4
        repeat (3) @(posedge clk_2);
        #1;
        chk("res_hold", int'(bus.res), SAT ? 3 : 0);
        chk("ovf_hold", int'(bus.ovf), 1);

        do_reset();
        contention(4);

        // Reset while the operation is in EXEC: it is lost, no done follows.
        @(negedge clk_2);
        bus.op0 = 2'b00; bus.a0 = 3'b001; bus.b0 = 3'b001;
        bus.req = 2'b01;
        @(posedge clk_2);
        @(negedge clk_2);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", int'(bus.gnt), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_res", int'(bus.res), 0);
        chk("midrst_ops_done", int'(bus.ops_done), 0);
        bus.req = 2'b00;
        exp_cnt = 8'd0;
        @(negedge clk_2);
        rst_n = 1'b1;
        repeat (4) @(posedge clk_2);
        #1;
        chk("midrst_ops_after", int'(bus.ops_done), 0);

        contention(256);
        #1;
        chk("wrap_ops_done", int'(bus.ops_done), 0);

        repeat (4) @(posedge clk_2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Round-robin scheduler that shares one 3-bit signed ALU between two requesters on the `clk_2` domain. It uses the same operation encoding as the board ALU: AND, OR, ADD and SUB, with overflow detection on the signed range -4..3. Requests are granted one at a time through a request/grant/done handshake. The block sits between the switch/LED front-end logic and any sequencer that needs arithmetic, and keeps a count of completed operations for the LCD debug outputs.

## Interface
Parameters:
- `NREQ`, 2, number of requesters; fixed at 2, other values unsupported.
- `NBITS_OP`, 3, operand/result width (signed two's complement).
- `NBITS_CNT`, 8, width of the completed-operation counter.

Ports:
- `clk_2`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  [1:0]  level request per requester; held until its `done` bit.
- `op0`, `op1`  in  [1:0] each  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `a0`, `b0`, `a1`, `b1`  in  [2:0] each  signed operands.
- `gnt`  out  [1:0]  one-hot, one-cycle pulse: operands captured for that requester.
- `done`  out  [1:0]  one-hot, one-cycle pulse: `res`/`ovf` valid for that requester.
- `res`  out  [2:0]  signed result.
- `ovf`  out  1  result outside -4..3 (ADD/SUB only).
- `busy`  out  1  high while state is not IDLE.
- `ops_done`  out  [7:0]  completed operations, wraps modulo 256.

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
  - IDLE → EXEC when any `req` bit is high at the edge. Winner's op/a/b are latched, `gnt[winner]` asserts, and `last` is updated.
  - EXEC → RESP unconditionally. The ALU evaluates the latched operands, and `res`/`ovf` are registered.
  - RESP → IDLE unconditionally. `done[winner]` asserts and `ops_done` increments.
- Arbitration:
  - `last` register resets to 1, so requester 0 wins first.
  - If both requests are high, the winner is the requester ≠ `last`. If one is high, it wins.
- Arithmetic:
  - Operands are sign-extended to 4 bits. Y = A+B, A−B, A&B, or A|B.
  - ADD/SUB: `ovf`=1 iff Y < -4 or Y > 3.
  - AND/OR: `ovf`=0 always, and `res`=Y[2:0].
  - On overflow, `res` = 000 (macro off; see Configuration).
- `res` and `ovf` hold their last values until the next EXEC. They are not cleared at `done`.
- Sampling of `req`:
  - `req` is sampled only in IDLE. A request dropped before its grant is never served.
  - Inputs changing after `gnt` have no effect on that operation.
- If a requester still holds `req` in the cycle after its `done`, that is a new request.
- `ops_done` rolls over from 255 to 0 silently.
- Reset mid-operation: all registers are cleared immediately and the in-flight operation is lost. No `done` is issued.

## Timing
- Reset values:
  - FSM = IDLE, `last` = 1.
  - `gnt`=00, `done`=00, `res`=000, `ovf`=0, `busy`=0, `ops_done`=0.
- Request sampled at edge T (IDLE):
  - `gnt` is high in cycle T+1.
  - `done` is high in cycle T+2.
- Latency is 2 cycles from the sampling edge to `done`.
- Throughput is one operation per 3 cycles. The earliest next sampling edge is T+3.
- `busy` is high in cycles T+1 and T+2.
- `gnt` and `done` are never both non-zero in the same cycle. Each is at most one-hot.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `ALU_SAT_EN` defined:
  - ADD/SUB overflow saturates `res` to 011 (Y > 3) or 100 (Y < -4).
  - `ovf` is still 1.
- `ALU_SAT_EN` undefined:
  - Overflowed results are forced to 000 with `ovf`=1, matching the board display's blank-on-overflow behaviour.
- No other behaviour differs between the two builds.

## Test plan
- Reset, then single request:
  - Stimulus: `req`=01, op0=00, a0=001, b0=010.
  - Response: `gnt`=01 at T+1, `done`=01 at T+2, `res`=011, `ovf`=0, `ops_done`=1.
- Overflow on ADD:
  - Stimulus: a0=011, b0=001, op0=00.
  - Response: `ovf`=1. `res`=000, or 011 with `ALU_SAT_EN`.
- Overflow on SUB:
  - Stimulus: a1=100, b1=001, op1=01.
  - Response: `ovf`=1. `res`=000, or 100 with `ALU_SAT_EN`.
- Contention:
  - Stimulus: `req`=11 held from reset for 4 operations, op0=10 (101&011), op1=11 (100|001).
  - Response:
    - `done` order is 01, 10, 01, 10.
    - Results are 001 for requester 0 and 101 for requester 1.
    - `done` pulses are 3 cycles apart.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during EXEC.
  - Response: outputs go to reset values immediately, no `done` pulse follows, and `ops_done` stays 0.
- Counter wrap:
  - Stimulus: 256 back-to-back requests.
  - Response: `ops_done` reads 255 then 0, and arbitration is unaffected.
